mod_limit_loader: RTL and testbench

MOD_LIMIT_LOADER -- requirements
Module: mod_limit_loader

---
 rtl/mod_limit_loader.sv | 115 +++++++++++
 tb/tb_mod_limit_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mod_limit_loader.sv
// mod_limit_loader: takes a new terminal-count limit through a valid/ready
// handshake, holds it in a shadow register, and applies it to limit_out only
// when the downstream modulus counter wraps (q_in == limit_out). Doing the
// swap at the wrap means the counter always restarts from 0 under the new limit.
// Optional build macro MOD_LIMIT_WRAP_COUNT_EN compiles in the saturating wrap
// counter. Without it, wrap_cnt is tied to 0.
module mod_limit_loader #(
  parameter int unsigned N           = 3,
  parameter int unsigned W           = 8,
  parameter int unsigned RESET_LIMIT = 2**N - 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         lim_valid,
  input  logic [N-1:0] lim_data,
  output logic         lim_ready,
  input  logic [N-1:0] q_in,
  output logic [N-1:0] limit_out,
  output logic         pending,
  output logic         wrap_pulse,
  output logic [W-1:0] wrap_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [N-1:0]   limit_q, limit_d;
  logic           lim_ready_q, lim_ready_d;
  logic           pending_q, pending_d;
  logic           wrap_pulse_q, wrap_pulse_d;
  logic           wrap_c;
  logic           xfer_c;

  assign wrap_c = (q_in == limit_q);
  assign xfer_c = lim_valid && lim_ready_q;

  // Next-state: capture in IDLE (even on a wrap edge), apply the shadow on a wrap in PEND
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    limit_d      = limit_q;
    wrap_pulse_d = wrap_c;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          shadow_d = lim_data;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (wrap_c) begin
          limit_d = shadow_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    lim_ready_d = (state_d == IDLE);
    pending_d   = (state_d == PEND);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      limit_q      <= N'(RESET_LIMIT);
      lim_ready_q  <= 1'b1;
      pending_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      limit_q      <= limit_d;
      lim_ready_q  <= lim_ready_d;
      pending_q    <= pending_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign lim_ready  = lim_ready_q;
  assign pending    = pending_q;
  assign limit_out  = limit_q;
  assign wrap_pulse = wrap_pulse_q;

`ifdef MOD_LIMIT_WRAP_COUNT_EN
  logic [W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Saturating wrap counter: holds at all-ones instead of rolling over
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_c && (wrap_cnt_q != {W{1'b1}})) begin
      wrap_cnt_d = wrap_cnt_q + W'(1);
    end
  end

  // Wrap counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = {W{1'b0}};
`endif

endmodule

// File: tb/tb_mod_limit_loader.sv
// Directed bench for mod_limit_loader (N=3, W=2). The bench drives inputs
// 1 time unit after the rising edge and samples outputs 1 time unit after the
// rising edge.
module tb_mod_limit_loader;

  localparam int unsigned N = 3;
  localparam int unsigned W = 2;
`ifdef MOD_LIMIT_WRAP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         lim_valid;
  logic [N-1:0] lim_data;
  logic         lim_ready;
  logic [N-1:0] q_in;
  logic [N-1:0] limit_out;
  logic         pending;
  logic         wrap_pulse;
  logic [W-1:0] wrap_cnt;

  int total = 0;
  int bad   = 0;
  int wraps = 0;

  mod_limit_loader #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lim_valid  (lim_valid),
    .lim_data   (lim_data),
    .lim_ready  (lim_ready),
    .q_in       (q_in),
    .limit_out  (limit_out),
    .pending    (pending),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected wrap count: saturates at 3 when compiled in, otherwise always 0
  function automatic int exp_cnt();
    if (!CNT_EN) return 0;
    return (wraps > 3) ? 3 : wraps;
  endfunction

  // Apply inputs, take one rising edge, settle to the sampling point
  task automatic step(input logic v, input int d, input int q);
    lim_valid = v;
    lim_data  = N'(d);
    q_in      = N'(q);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int lim, input int pend, input int pulse);
    chk({tag, ".limit"},   int'(limit_out),  lim);
    chk({tag, ".pending"}, int'(pending),    pend);
    chk({tag, ".ready"},   int'(lim_ready),  1 - pend);
    chk({tag, ".pulse"},   int'(wrap_pulse), pulse);
    chk({tag, ".cnt"},     int'(wrap_cnt),   exp_cnt());
  endtask

  initial begin
    reset_n = 1'b0; lim_valid = 1'b0; lim_data = '0; q_in = '0;
    #12;
    chk_all("reset", 7, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Wrap at the reset limit of 7
    step(0, 0, 7); wraps++;
    chk_all("wrap7", 7, 0, 1);
    step(0, 0, 0);
    chk_all("after_wrap7", 7, 0, 0);

    // Transfer 4 at q=2, held through q=3..6, applied at q=7
    step(0, 0, 1);
    step(1, 4, 2);
    chk_all("xfer4", 7, 1, 0);
    for (int q = 3; q <= 6; q++) begin
      step(0, 0, q);
      chk_all("hold4", 7, 1, 0);
    end
    step(0, 0, 7); wraps++;
    chk_all("apply4", 4, 0, 1);

    // Transfer 5 on a wrap edge in IDLE: capture only, apply at next wrap
    step(1, 5, 4); wraps++;
    chk_all("xfer5_on_wrap", 4, 1, 1);
    for (int q = 0; q <= 3; q++) begin
      step(0, 0, q);
      chk_all("hold5", 4, 1, 0);
    end
    step(0, 0, 4); wraps++;
    chk_all("apply5", 5, 0, 1);

    // Capture 1, then PEND ignores data 2/3 until back in IDLE
    step(1, 1, 0);
    chk_all("xfer1", 5, 1, 0);
    step(1, 2, 1);
    step(1, 2, 2);
    chk_all("stall2", 5, 1, 0);
    step(1, 3, 5); wraps++;
    chk_all("apply1_nocap", 1, 0, 1);
    step(1, 3, 0);
    chk_all("xfer3", 1, 1, 0);
    step(0, 0, 1); wraps++;
    chk_all("apply3", 3, 0, 1);

    // Reset mid-PEND with shadow=1 discards it
    step(1, 1, 0);
    chk_all("xfer1b", 3, 1, 0);
    lim_valid = 1'b0;
    reset_n = 1'b0; wraps = 0;
    #2;
    chk_all("async_reset", 7, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // First edge after reset: wrap at 7 and transfer 0 together
    step(1, 0, 7); wraps++;
    chk_all("post_reset_xfer0", 7, 1, 1);
    step(0, 0, 7); wraps++;
    chk_all("apply0", 0, 0, 1);

    // Limit 0: every edge wraps; transfer 6 captures, applies next edge
    step(0, 0, 0); wraps++;
    chk_all("lim0_a", 0, 0, 1);
    step(1, 6, 0); wraps++;
    chk_all("lim0_xfer6", 0, 1, 1);
    step(0, 0, 0); wraps++;
    chk_all("apply6", 6, 0, 1);
    step(0, 0, 0);
    chk_all("final", 6, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
